// File: rtl/mul24_arbiter.sv
// Round-robin sharing of one fixed-latency, non-stallable multiplier core between two requesters.
// Optional performance counters are built when MUL24_ARBITER_PERF_EN is defined.
module mul24_arbiter_fifo #(
  parameter int DW    = 48,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic          valid,
  output logic [DW-1:0] head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [PW-1:0]            wptr, rptr;
  logic [CW-1:0]            cnt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid = (cnt != '0);
  assign head  = mem[rptr];

  // No full check: upstream credits keep writes within DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= wdata;
        wptr      <= nxt(wptr);
      end
      if (rd) rptr <= nxt(rptr);
      case ({wr, rd})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

module mul24_arbiter #(
  parameter int W     = 24,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           r0_valid,
  output logic           r0_ready,
  input  logic [W-1:0]   r0_a,
  input  logic [W-1:0]   r0_b,
  input  logic           r1_valid,
  output logic           r1_ready,
  input  logic [W-1:0]   r1_a,
  input  logic [W-1:0]   r1_b,
  output logic           res0_valid,
  input  logic           res0_ready,
  output logic [2*W-1:0] res0_p,
  output logic           res1_valid,
  input  logic           res1_ready,
  output logic [2*W-1:0] res1_p,
  output logic           mul_valid,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_p,
  output logic           busy,
  output logic [31:0]    perf_issue0,
  output logic [31:0]    perf_issue1,
  output logic [31:0]    perf_stall
);
  localparam int NUM_REQ = 2;
  localparam int CW      = $clog2(DEPTH + 1);

  logic [NUM_REQ-1:0]             req_valid, eligible, grant, pop, wr;
  logic [NUM_REQ-1:0][W-1:0]      req_a, req_b;
  logic [NUM_REQ-1:0][CW-1:0]     credit;
  logic [NUM_REQ-1:0]             res_valid, res_ready;
  logic [NUM_REQ-1:0][2*W-1:0]    res_p;
  logic                           last_grant, sel;
  logic [LAT:0]                   vld_pipe, tag_pipe;

  assign req_valid = {r1_valid, r0_valid};
  assign req_a     = {r1_a, r0_a};
  assign req_b     = {r1_b, r0_b};
  assign res_ready = {res1_ready, res0_ready};
  assign {res1_valid, res0_valid} = res_valid;
  assign res0_p    = res_p[0];
  assign res1_p    = res_p[1];

  // grant is only raised with valid, so grant doubles as the handshake.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = rst & req_valid[i] & (credit[i] < CW'(DEPTH));
    if (&eligible) grant = last_grant ? 2'b01 : 2'b10;
    else           grant = eligible;
  end

  assign r0_ready  = grant[0];
  assign r1_ready  = grant[1];
  assign sel       = grant[1];
  assign mul_valid = vld_pipe[0];

  // Stage k holds the entry issued k cycles ago; stage LAT lines up with mul_p.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe   <= '0;
      tag_pipe   <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      last_grant <= 1'b1;
    end else begin
      vld_pipe <= {vld_pipe[LAT-1:0], |grant};
      tag_pipe <= {tag_pipe[LAT-1:0], sel};
      if (|grant) begin
        mul_a      <= req_a[sel];
        mul_b      <= req_b[sel];
        last_grant <= sel;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    logic [CW-1:0] cred;

    assign wr[i]     = vld_pipe[LAT] & (int'(tag_pipe[LAT]) == i);
    assign pop[i]    = res_valid[i] & res_ready[i];
    assign credit[i] = cred;

    always_ff @(posedge clk) begin
      if (!rst) cred <= '0;
      else case ({grant[i], pop[i]})
        2'b10:   cred <= cred + CW'(1);
        2'b01:   cred <= cred - CW'(1);
        default: ;
      endcase
    end

    mul24_arbiter_fifo #(.DW(2*W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr[i]),
      .wdata (mul_p),
      .rd    (pop[i]),
      .valid (res_valid[i]),
      .head  (res_p[i])
    );
  end

  assign busy = (credit[0] != '0) | (credit[1] != '0);

`ifdef MUL24_ARBITER_PERF_EN
  logic [31:0] cnt_issue0, cnt_issue1, cnt_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_issue0 <= '0;
      cnt_issue1 <= '0;
      cnt_stall  <= '0;
    end else begin
      if (grant[0]) cnt_issue0 <= cnt_issue0 + 32'd1;
      if (grant[1]) cnt_issue1 <= cnt_issue1 + 32'd1;
      if (|(req_valid & ~grant)) cnt_stall <= cnt_stall + 32'd1;
    end
  end

  assign perf_issue0 = cnt_issue0;
  assign perf_issue1 = cnt_issue1;
  assign perf_stall  = cnt_stall;
`else
  assign perf_issue0 = '0;
  assign perf_issue1 = '0;
  assign perf_stall  = '0;
`endif
endmodule

// File: tb/tb_mul24_arbiter.sv
// Directed bench for mul24_arbiter: handshake timing, round-robin, credits, reset, perf counters.
module tb_mul24_arbiter;
  localparam int W = 24, LAT = 3, DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_valid, r0_ready, r1_valid, r1_ready;
  logic [W-1:0]  r0_a, r0_b, r1_a, r1_b;
  logic          res0_valid, res0_ready, res1_valid, res1_ready;
  logic [47:0]   res0_p, res1_p;
  logic          mul_valid;
  logic [W-1:0]  mul_a, mul_b;
  logic [47:0]   mul_p;
  logic          busy;
  logic [31:0]   perf_issue0, perf_issue1, perf_stall;

  int checks = 0;
  int errors = 0;

  logic [23:0] ta0 [0:3] = '{24'h000002, 24'h000100, 24'hFFFFFF, 24'h123456};
  logic [23:0] tb0 [0:3] = '{24'h000003, 24'h000100, 24'hFFFFFF, 24'h000010};
  logic [47:0] tp0 [0:3] = '{48'h6, 48'h10000, 48'hFFFFFE000001, 48'h1234560};
  logic [23:0] ta1 [0:3] = '{24'h000007, 24'hFFFFFF, 24'h800000, 24'h000000};
  logic [23:0] tb1 [0:3] = '{24'h000009, 24'h000001, 24'h000002, 24'hABCDEF};
  logic [47:0] tp1 [0:3] = '{48'h3F, 48'hFFFFFF, 48'h1000000, 48'h0};

  always #5 clk = ~clk;

  mul24_arbiter #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_p(res0_p),
    .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_p(res1_p),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .busy(busy), .perf_issue0(perf_issue0), .perf_issue1(perf_issue1), .perf_stall(perf_stall)
  );

  // Core model: LAT-cycle pipelined multiplier.
  logic [47:0] prod;
  logic [47:0] core_pipe [0:2];
  assign prod  = {24'h0, mul_a} * {24'h0, mul_b};
  assign mul_p = core_pipe[2];
  always @(posedge clk) begin
    core_pipe[0] <= mul_valid ? prod : 48'h0;
    core_pipe[1] <= core_pipe[0];
    core_pipe[2] <= core_pipe[1];
  end

  // Outstanding-count model from observed handshakes and pops; flags any excess over DEPTH.
  int out0 = 0, out1 = 0, ovf = 0;
  always @(posedge clk) begin
    if (!rst) begin
      out0 <= 0;
      out1 <= 0;
    end else begin
      out0 <= out0 + int'(r0_valid & r0_ready) - int'(res0_valid & res0_ready);
      out1 <= out1 + int'(r1_valid & r1_ready) - int'(res1_valid & res1_ready);
      if (out0 > DEPTH || out1 > DEPTH) ovf <= ovf + 1;
    end
  end

  task automatic do_reset();
    rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; r0_valid = 1'b1; r1_valid = 1'b1;
    r0_a = 24'h1; r0_b = 24'h1; r1_a = 24'h1; r1_b = 24'h1;
    res0_ready = 1'b0; res1_ready = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (r0_ready !== 1'b0) begin errors++; $display("FAIL reset_r0_ready: got %b expected 0", r0_ready); end
    checks++; if (r1_ready !== 1'b0) begin errors++; $display("FAIL reset_r1_ready: got %b expected 0", r1_ready); end
    checks++; if (mul_valid !== 1'b0) begin errors++; $display("FAIL reset_mul_valid: got %b expected 0", mul_valid); end
    checks++; if ({mul_a, mul_b} !== 48'h0) begin errors++; $display("FAIL reset_mul_ab: got %h expected 0", {mul_a, mul_b}); end
    checks++; if ({res0_valid, res1_valid} !== 2'b00) begin errors++; $display("FAIL reset_res_valid: got %b expected 00", {res0_valid, res1_valid}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    r0_valid = 1'b0; r1_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_op();
    res0_ready = 1'b0; r0_valid = 1'b1; r0_a = 24'h000003; r0_b = 24'h000005; #1;
    checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", r0_ready); end
    @(negedge clk); r0_valid = 1'b0; #1;
    checks++; if ({mul_valid, mul_a, mul_b} !== {1'b1, 24'h3, 24'h5}) begin errors++; $display("FAIL single_issue: got %b %h %h expected 1 3 5", mul_valid, mul_a, mul_b); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    @(negedge clk); #1;
    checks++; if (mul_valid !== 1'b0) begin errors++; $display("FAIL single_issue_once: got %b expected 0", mul_valid); end
    @(negedge clk); @(negedge clk); #1;
    checks++; if (res0_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0 in cycle 4", res0_valid); end
    @(negedge clk); #1;
    checks++; if ({res0_valid, res0_p} !== {1'b1, 48'hF}) begin errors++; $display("FAIL single_result: got %b %h expected 1 f", res0_valid, res0_p); end
    res0_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if ({res0_valid, busy} !== 2'b00) begin errors++; $display("FAIL single_drain: got valid=%b busy=%b expected 0 0", res0_valid, busy); end
  endtask

  task automatic test_contention();
    int i0 = 0, i1 = 0, n0 = 0, n1 = 0;
    do_reset();
    res0_ready = 1'b1; res1_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      r0_valid = (i0 < 4); r0_a = ta0[i0 & 3]; r0_b = tb0[i0 & 3];
      r1_valid = (i1 < 4); r1_a = ta1[i1 & 3]; r1_b = tb1[i1 & 3];
      #1;
      if (c < 8) begin
        checks++; if ({r1_ready, r0_ready} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_grant c%0d: got r1r0=%b%b expected %s", c, r1_ready, r0_ready, (c % 2 == 0) ? "01" : "10"); end
      end
      if (c >= 1 && c <= 8) begin
        checks++; if (mul_valid !== 1'b1) begin errors++; $display("FAIL rr_issue_rate c%0d: got %b expected 1", c, mul_valid); end
      end
      if (res0_valid) begin
        checks++; if (n0 >= 4 || res0_p !== tp0[n0 & 3]) begin errors++; $display("FAIL rr_res0 #%0d: got %h expected %h", n0, res0_p, tp0[n0 & 3]); end
        n0++;
      end
      if (res1_valid) begin
        checks++; if (n1 >= 4 || res1_p !== tp1[n1 & 3]) begin errors++; $display("FAIL rr_res1 #%0d: got %h expected %h", n1, res1_p, tp1[n1 & 3]); end
        n1++;
      end
      if (r0_valid && r0_ready) i0++;
      if (r1_valid && r1_ready) i1++;
      @(negedge clk);
    end
    #1;
    checks++; if (n0 != 4 || n1 != 4 || busy !== 1'b0) begin errors++; $display("FAIL rr_counts: got n0=%0d n1=%0d busy=%b expected 4 4 0", n0, n1, busy); end
  endtask

  task automatic test_backpressure();
    bit got = 0;
    do_reset();
    res0_ready = 1'b0; res1_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      r0_valid = 1'b1; r0_a = (c < 4) ? 24'(c + 1) : 24'h5; r0_b = 24'h2; #1;
      checks++; if (r0_ready !== (c < 4)) begin errors++; $display("FAIL bp_ready c%0d: got %b expected %b", c, r0_ready, (c < 4)); end
      @(negedge clk);
    end
    r1_valid = 1'b1; r1_a = 24'h3; r1_b = 24'h4; #1;
    checks++; if ({r1_ready, r0_ready} !== 2'b10) begin errors++; $display("FAIL bp_r1_unaffected: got r1r0=%b%b expected 10", r1_ready, r0_ready); end
    @(negedge clk); r1_valid = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (res1_valid) begin
        got = 1;
        checks++; if (res1_p !== 48'hC) begin errors++; $display("FAIL bp_r1_result: got %h expected c", res1_p); end
      end
      @(negedge clk);
    end
    checks++; if (!got) begin errors++; $display("FAIL bp_r1_timeout: got no res1_valid expected one within 10 cycles"); end
    res0_ready = 1'b1; #1;
    checks++; if ({res0_valid, res0_p, r0_ready} !== {1'b1, 48'h2, 1'b0}) begin errors++; $display("FAIL bp_pop: got %b %h ready=%b expected 1 2 0", res0_valid, res0_p, r0_ready); end
    @(negedge clk); res0_ready = 1'b0; #1;
    checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL bp_one_more: got %b expected 1", r0_ready); end
    @(negedge clk); #1;
    checks++; if (r0_ready !== 1'b0) begin errors++; $display("FAIL bp_full_again: got %b expected 0", r0_ready); end
    r0_valid = 1'b0;
  endtask

  task automatic test_pop_accept();
    logic [47:0] exp [0:3] = '{48'h8, 48'hA, 48'h2A, 48'h1};
    repeat (6) @(negedge clk);
    res0_ready = 1'b1; #1;
    checks++; if ({res0_valid, res0_p} !== {1'b1, 48'h4}) begin errors++; $display("FAIL pa_pop1: got %b %h expected 1 4", res0_valid, res0_p); end
    @(negedge clk); r0_valid = 1'b1; r0_a = 24'h6; r0_b = 24'h7; #1;
    checks++; if ({r0_ready, res0_p} !== {1'b1, 48'h6}) begin errors++; $display("FAIL pa_both: got ready=%b p=%h expected 1 6", r0_ready, res0_p); end
    @(negedge clk); r0_valid = 1'b0; res0_ready = 1'b0;
    @(negedge clk); r0_valid = 1'b1; r0_a = 24'h1; r0_b = 24'h1; #1;
    checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL pa_credit_held: got %b expected 1", r0_ready); end
    @(negedge clk); #1;
    checks++; if (r0_ready !== 1'b0) begin errors++; $display("FAIL pa_credit_full: got %b expected 0", r0_ready); end
    r0_valid = 1'b0;
    repeat (7) @(negedge clk);
    res0_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if ({res0_valid, res0_p} !== {1'b1, exp[k]}) begin errors++; $display("FAIL pa_order #%0d: got %b %h expected 1 %h", k, res0_valid, res0_p, exp[k]); end
      @(negedge clk);
    end
    #1;
    checks++; if ({res0_valid, busy} !== 2'b00) begin errors++; $display("FAIL pa_empty: got valid=%b busy=%b expected 0 0", res0_valid, busy); end
  endtask

  task automatic test_reset_midflight();
    bit stray = 0, got = 0;
    do_reset();
    res0_ready = 1'b1; res1_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      r0_valid = 1'b1; r0_a = 24'(c + 2); r0_b = 24'h3;
      @(negedge clk);
    end
    rst = 1'b0; #1;
    checks++; if (r0_ready !== 1'b0) begin errors++; $display("FAIL mf_ready_in_reset: got %b expected 0", r0_ready); end
    @(negedge clk); rst = 1'b1; r0_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1; if (res0_valid || res1_valid) stray = 1;
      @(negedge clk);
    end
    checks++; if (stray) begin errors++; $display("FAIL mf_stray_result: got res_valid after reset expected none"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mf_busy: got %b expected 0", busy); end
    r1_valid = 1'b1; r1_a = 24'h000ABC; r1_b = 24'h000100; #1;
    checks++; if (r1_ready !== 1'b1) begin errors++; $display("FAIL mf_r1_grant: got %b expected 1", r1_ready); end
    @(negedge clk); r1_valid = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (res0_valid) stray = 1;
      if (res1_valid) begin
        got = 1;
        checks++; if (res1_p !== 48'hABC00) begin errors++; $display("FAIL mf_r1_result: got %h expected abc00", res1_p); end
      end
      @(negedge clk);
    end
    checks++; if (!got || stray) begin errors++; $display("FAIL mf_r1_delivery: got res1=%b stray_res0=%b expected 1 0", got, stray); end
  endtask

  task automatic test_perf();
    logic [31:0] e_i0, e_i1, e_st;
`ifdef MUL24_ARBITER_PERF_EN
    e_i0 = 32'd10; e_i1 = 32'd6; e_st = 32'd4;
`else
    e_i0 = 32'd0;  e_i1 = 32'd0; e_st = 32'd0;
`endif
    do_reset();
    res0_ready = 1'b0; res1_ready = 1'b1;
    r0_valid = 1'b1; r0_a = 24'h1; r0_b = 24'h1;
    repeat (8) @(negedge clk);
    r0_valid = 1'b0; res0_ready = 1'b1;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      r0_valid = (k % 2 == 0); r1_valid = (k % 2 == 1);
      r0_a = 24'(k); r1_a = 24'(k); r0_b = 24'h2; r1_b = 24'h3;
      @(negedge clk);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (perf_issue0 !== e_i0) begin errors++; $display("FAIL perf_issue0: got %0d expected %0d", perf_issue0, e_i0); end
    checks++; if (perf_issue1 !== e_i1) begin errors++; $display("FAIL perf_issue1: got %0d expected %0d", perf_issue1, e_i1); end
    checks++; if (perf_stall !== e_st) begin errors++; $display("FAIL perf_stall: got %0d expected %0d", perf_stall, e_st); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL perf_busy: got %b expected 0", busy); end
  endtask

  task automatic test_no_overflow();
    checks++; if (ovf != 0) begin errors++; $display("FAIL no_overflow: got %0d excess cycles expected 0", ovf); end
  endtask

  initial begin
    rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
    r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    res0_ready = 1'b0; res1_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_pop_accept();
    test_reset_midflight();
    test_perf();
    test_no_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
